// File: rtl/lcd12864_bus_sink.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lcd12864_bus_sink                                             |
// | Function : device-side LCD12864 write-bus sink with 4x16 shadow DDRAM.   |
// |            Optional trace port enabled by LCD_SINK_TRACE_EN.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module lcd12864_bus_sink #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] CLR_CHAR    = 8'h20
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        LCD_RS,
   input  logic        LCD_E,
   input  logic [7:0]  LCD_D,
   input  logic [5:0]  rd_addr,
   output logic [7:0]  rd_data,
   output logic [5:0]  cur_addr,
   output logic        disp_on,
   output logic        busy,
   output logic        cmd_err,
   output logic        ovr_err,
   output logic [15:0] xfer_cnt,
   output logic        trace_valid,
   output logic        trace_rs,
   output logic [7:0]  trace_d
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DECODE = 2'd1,
      S_CLEAR  = 2'd2
   } state_t;

   localparam logic [5:0] c_last_idx = 6'd63;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [SYNC_STAGES-1:0] r_e_sync;
   logic               r_e_last;
   logic               w_cap;

   logic               r_cmd_rs;
   logic [7:0]         r_cmd_d;
   logic [5:0]         r_clr_idx;
   logic [5:0]         r_cur_addr;
   logic               r_inc;
   logic               r_disp_on;
   logic               r_cmd_err;
   logic               r_ovr_err;
   logic [15:0]        r_xfer_cnt;
   logic [7:0]         r_rd_data;
   logic [7:0]         r_ram [0:63];

   logic               w_latch;
   logic               w_we;
   logic [5:0]         w_waddr;
   logic [7:0]         w_wdata;
   logic [5:0]         w_clr_idx_nxt;
   logic [5:0]         w_addr_nxt;
   logic               w_inc_nxt;
   logic               w_disp_nxt;
   logic               w_cmd_err_nxt;
   logic               w_ovr_err_nxt;

   // E is asynchronous to CLK; RS/D are quasi-static around its falling edge.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_e_sync <= '0;
         r_e_last <= 1'b0;
      end else begin
         r_e_sync <= {r_e_sync[SYNC_STAGES-2:0], LCD_E};
         r_e_last <= r_e_sync[SYNC_STAGES-1];
      end
   end

   assign w_cap = r_e_last & ~r_e_sync[SYNC_STAGES-1];

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_latch       = 1'b0;
      w_we          = 1'b0;
      w_waddr       = r_cur_addr;
      w_wdata       = r_cmd_d;
      w_clr_idx_nxt = r_clr_idx;
      w_addr_nxt    = r_cur_addr;
      w_inc_nxt     = r_inc;
      w_disp_nxt    = r_disp_on;
      w_cmd_err_nxt = r_cmd_err;
      w_ovr_err_nxt = r_ovr_err;
      case (r_state)
         S_IDLE: begin
            if (w_cap) begin
               w_latch     = 1'b1;
               w_state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            w_state_nxt = S_IDLE;
            if (w_cap) begin
               w_ovr_err_nxt = 1'b1;
            end
            if (r_cmd_rs) begin
               w_we       = 1'b1;
               w_addr_nxt = r_inc ? (r_cur_addr + 6'd1) : (r_cur_addr - 6'd1);
            end else if (r_cmd_d[7]) begin
               if (r_cmd_d[6:5] == 2'b00) begin
                  // ST7920 row order: 0x80,0x90,0x88,0x98; each address holds two chars
                  w_addr_nxt = {r_cmd_d[3], r_cmd_d[4], r_cmd_d[2:0], 1'b0};
               end else begin
                  w_cmd_err_nxt = 1'b1;
               end
            end else if (r_cmd_d[7:5] == 3'b001) begin
               w_addr_nxt = r_cur_addr;
            end else if (r_cmd_d[7:3] == 5'b00001) begin
               w_disp_nxt = r_cmd_d[2];
            end else if (r_cmd_d[7:2] == 6'b000001) begin
               w_inc_nxt = r_cmd_d[1];
            end else if (r_cmd_d == 8'h01) begin
               w_addr_nxt    = 6'd0;
               w_inc_nxt     = 1'b1;
               w_clr_idx_nxt = 6'd0;
               w_state_nxt   = S_CLEAR;
            end else if (r_cmd_d[7:1] == 7'b0000001) begin
               w_addr_nxt = 6'd0;
            end else begin
               w_cmd_err_nxt = 1'b1;
            end
         end
         S_CLEAR: begin
            w_we          = 1'b1;
            w_waddr       = r_clr_idx;
            w_wdata       = CLR_CHAR;
            w_clr_idx_nxt = r_clr_idx + 6'd1;
            if (r_clr_idx == c_last_idx) begin
               w_state_nxt = S_IDLE;
            end
            if (w_cap) begin
               w_ovr_err_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_cmd_rs   <= 1'b0;
         r_cmd_d    <= 8'h00;
         r_clr_idx  <= 6'd0;
         r_cur_addr <= 6'd0;
         r_inc      <= 1'b1;
         r_disp_on  <= 1'b0;
         r_cmd_err  <= 1'b0;
         r_ovr_err  <= 1'b0;
         r_xfer_cnt <= 16'd0;
         r_rd_data  <= 8'h00;
      end else begin
         if (w_latch) begin
            r_cmd_rs <= LCD_RS;
            r_cmd_d  <= LCD_D;
         end
         if (w_cap) begin
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
         end
         r_clr_idx  <= w_clr_idx_nxt;
         r_cur_addr <= w_addr_nxt;
         r_inc      <= w_inc_nxt;
         r_disp_on  <= w_disp_nxt;
         r_cmd_err  <= w_cmd_err_nxt;
         r_ovr_err  <= w_ovr_err_nxt;
         r_rd_data  <= r_ram[rd_addr];
      end
   end

   // Contents deliberately survive reset so a mid-sweep reset leaves partial fill.
   always_ff @(posedge CLK) begin
      if (w_we) begin
         r_ram[w_waddr] <= w_wdata;
      end
   end

   assign rd_data  = r_rd_data;
   assign cur_addr = r_cur_addr;
   assign disp_on  = r_disp_on;
   assign busy     = (r_state == S_CLEAR);
   assign cmd_err  = r_cmd_err;
   assign ovr_err  = r_ovr_err;
   assign xfer_cnt = r_xfer_cnt;

`ifdef LCD_SINK_TRACE_EN
   logic       r_trace_valid;
   logic       r_trace_rs;
   logic [7:0] r_trace_d;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_trace_valid <= 1'b0;
         r_trace_rs    <= 1'b0;
         r_trace_d     <= 8'h00;
      end else begin
         r_trace_valid <= w_cap;
         if (w_cap) begin
            r_trace_rs <= LCD_RS;
            r_trace_d  <= LCD_D;
         end
      end
   end

   assign trace_valid = r_trace_valid;
   assign trace_rs    = r_trace_rs;
   assign trace_d     = r_trace_d;
`else
   assign trace_valid = 1'b0;
   assign trace_rs    = 1'b0;
   assign trace_d     = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lcd12864_bus_sink.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_lcd12864_bus_sink                                          |
// | Function : self-checking bench for lcd12864_bus_sink (scoreboard reads). |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_lcd12864_bus_sink;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        LCD_RS = 1'b0;
   logic        LCD_E = 1'b0;
   logic [7:0]  LCD_D = 8'h00;
   logic [5:0]  rd_addr = 6'd0;
   logic [7:0]  rd_data;
   logic [5:0]  cur_addr;
   logic        disp_on;
   logic        busy;
   logic        cmd_err;
   logic        ovr_err;
   logic [15:0] xfer_cnt;
   logic        trace_valid;
   logic        trace_rs;
   logic [7:0]  trace_d;

   lcd12864_bus_sink #(
      .SYNC_STAGES (2),
      .CLR_CHAR    (8'h20)
   ) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .LCD_RS      (LCD_RS),
      .LCD_E       (LCD_E),
      .LCD_D       (LCD_D),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .cur_addr    (cur_addr),
      .disp_on     (disp_on),
      .busy        (busy),
      .cmd_err     (cmd_err),
      .ovr_err     (ovr_err),
      .xfer_cnt    (xfer_cnt),
      .trace_valid (trace_valid),
      .trace_rs    (trace_rs),
      .trace_d     (trace_d)
   );

   always #10 CLK = ~CLK;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         n_trace  = 0;
   logic [7:0] exp_q [$];
   logic       rd_req  = 1'b0;
   logic       rd_seen = 1'b0;

   // reference model state
   logic [7:0] exp_ram [64];
   logic [5:0] m_addr    = 6'd0;
   logic       m_id      = 1'b1;
   logic       m_disp    = 1'b0;
   logic       m_cmd_err = 1'b0;
   int         m_xfer    = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   always @(posedge CLK) begin
      rd_seen <= rd_req;
      if (trace_valid) n_trace++;
   end

   always @(negedge CLK) begin
      if (rd_seen) begin
         if (exp_q.size() == 0) check_eq("sb_nonempty", exp_q.size(), 1);
         else check_eq("rd_data", rd_data, exp_q.pop_front());
      end
   end

   task automatic read_range(input int start, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         rd_addr = 6'((start + i) % 64);
         rd_req  = 1'b1;
         exp_q.push_back(exp_ram[(start + i) % 64]);
      end
      @(negedge CLK);
      rd_req = 1'b0;
      @(negedge CLK);
   endtask

   task automatic model_update(input logic rs, input logic [7:0] d);
      int row;
      m_xfer++;
      if (rs) begin
         exp_ram[m_addr] = d;
         m_addr = m_id ? m_addr + 6'd1 : m_addr - 6'd1;
      end else begin
         casez (d)
            8'b1???????: begin
               if (d[6:5] != 2'b00) m_cmd_err = 1'b1;
               else begin
                  row = (d[4] ? 1 : 0) + (d[3] ? 2 : 0);
                  m_addr = 6'(row * 16 + int'(d[2:0]) * 2);
               end
            end
            8'b001?????: ;
            8'b00001???: m_disp = d[2];
            8'b000001??: m_id = d[1];
            8'h01: begin
               m_addr = 6'd0;
               m_id   = 1'b1;
               foreach (exp_ram[i]) exp_ram[i] = 8'h20;
            end
            8'h02, 8'h03: m_addr = 6'd0;
            default: m_cmd_err = 1'b1;
         endcase
      end
   endtask

   task automatic send(input logic rs, input logic [7:0] d);
      int busy_cycles = 0;
      @(negedge CLK);
      LCD_RS = rs;
      LCD_D  = d;
      LCD_E  = 1'b1;
      repeat (4) @(negedge CLK);
      LCD_E = 1'b0;
      if (!rs && d == 8'h01) begin
         for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (busy) busy_cycles++;
            else if (busy_cycles > 0) break;
         end
         check_eq("clear_busy_cycles", busy_cycles, 64);
      end else begin
         repeat (8) @(negedge CLK);
      end
      model_update(rs, d);
      check_eq("cur_addr", cur_addr, m_addr);
      check_eq("disp_on", disp_on, m_disp);
      check_eq("cmd_err", cmd_err, m_cmd_err);
      check_eq("busy_idle", busy, 0);
   endtask

   task automatic wait_not_busy();
      for (int i = 0; i < 200; i++) begin
         @(negedge CLK);
         if (!busy) break;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      foreach (exp_ram[i]) exp_ram[i] = 8'hxx;
      repeat (3) @(negedge CLK);
      check_eq("rst_rd_data", rd_data, 0);
      check_eq("rst_cur_addr", cur_addr, 0);
      check_eq("rst_disp_on", disp_on, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_cmd_err", cmd_err, 0);
      check_eq("rst_ovr_err", ovr_err, 0);
      check_eq("rst_xfer_cnt", xfer_cnt, 0);
      check_eq("rst_trace_valid", trace_valid, 0);
      RST_N = 1'b1;
      repeat (3) @(negedge CLK);

      // controller init sequence
      send(0, 8'h30);
      send(0, 8'h30);
      send(0, 8'h0C);
      send(0, 8'h01);
      send(0, 8'h06);
      check_eq("init_disp_on", disp_on, 1);
      check_eq("init_xfer_cnt", xfer_cnt, 5);
      read_range(0, 64);

      // row 1 text
      send(0, 8'h90);
      send(1, 8'h41);
      send(1, 8'h42);
      check_eq("ab_cur_addr", cur_addr, 18);
      read_range(16, 2);

      // full four-row writer, random printable text
      foreach (exp_ram[i]) exp_ram[i] = exp_ram[i];
      for (int r = 0; r < 4; r++) begin
         logic [7:0] rows [4];
         rows[0] = 8'h80; rows[1] = 8'h90; rows[2] = 8'h88; rows[3] = 8'h98;
         send(0, rows[r]);
         for (int c = 0; c < 16; c++) send(1, 8'($urandom_range(32, 126)));
      end
      check_eq("wrap_cur_addr", cur_addr, 0);
      read_range(0, 64);

      // decrement mode with 0 -> 63 wrap
      send(0, 8'h80);
      send(0, 8'h04);
      send(1, 8'hA1);
      check_eq("dec_addr_1", cur_addr, 63);
      send(1, 8'hA2);
      check_eq("dec_addr_2", cur_addr, 62);
      send(1, 8'hA3);
      check_eq("dec_addr_3", cur_addr, 61);
      read_range(62, 3);
      send(0, 8'h06);

      // home
      send(0, 8'h90);
      send(1, 8'h78);
      send(0, 8'h02);
      check_eq("home_cur_addr", cur_addr, 0);

      // clear followed closely by a data byte: byte is dropped
      check_eq("pre_ovr_err", ovr_err, 0);
      @(negedge CLK);
      LCD_RS = 1'b0; LCD_D = 8'h01; LCD_E = 1'b1;
      repeat (4) @(negedge CLK);
      LCD_E = 1'b0;
      repeat (4) @(negedge CLK);
      LCD_RS = 1'b1; LCD_D = 8'h55; LCD_E = 1'b1;
      repeat (2) @(negedge CLK);
      LCD_E = 1'b0;
      wait_not_busy();
      repeat (2) @(negedge CLK);
      m_xfer += 2;
      m_addr = 6'd0;
      m_id   = 1'b1;
      foreach (exp_ram[i]) exp_ram[i] = 8'h20;
      check_eq("ovr_err_set", ovr_err, 1);
      check_eq("ovr_busy_done", busy, 0);
      check_eq("ovr_xfer_cnt", xfer_cnt, 16'(m_xfer));
      check_eq("ovr_cur_addr", cur_addr, 0);
      read_range(0, 4);

      // unsupported commands
      send(0, 8'h88);
      check_eq("pre_err_cmd_err", cmd_err, 0);
      send(0, 8'hE0);
      check_eq("err_e0_cmd_err", cmd_err, 1);
      check_eq("err_e0_cur_addr", cur_addr, 32);
      send(0, 8'h40);
      check_eq("err_40_cur_addr", cur_addr, 32);
      send(1, 8'h5A);
      read_range(32, 1);
      send(0, 8'h08);
      check_eq("disp_off", disp_on, 0);
      check_eq("final_xfer_cnt", xfer_cnt, 16'(m_xfer));
`ifdef LCD_SINK_TRACE_EN
      check_eq("trace_pulses", n_trace, m_xfer);
`else
      check_eq("trace_pulses", n_trace, 0);
`endif

      // reset in the middle of a clear sweep
      @(negedge CLK);
      LCD_RS = 1'b0; LCD_D = 8'h01; LCD_E = 1'b1;
      repeat (4) @(negedge CLK);
      LCD_E = 1'b0;
      repeat (25) @(negedge CLK);
      check_eq("midclr_busy", busy, 1);
      RST_N = 1'b0;
      #3;
      check_eq("midclr_rst_busy", busy, 0);
      check_eq("midclr_rst_cur_addr", cur_addr, 0);
      check_eq("midclr_rst_cmd_err", cmd_err, 0);
      check_eq("midclr_rst_ovr_err", ovr_err, 0);
      check_eq("midclr_rst_xfer_cnt", xfer_cnt, 0);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      repeat (5) @(negedge CLK);
      check_eq("post_rst_busy", busy, 0);
      check_eq("sb_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
